// File: rtl/antifurto_pkg.sv
// Shared definitions for the anti-theft system: interval codes, default time
// parameters and the countdown timer state encoding.
package antifurto_pkg;

  typedef logic [1:0] interval_t;

  localparam interval_t INT_ARM       = 2'b00;
  localparam interval_t INT_DRIVER    = 2'b01;
  localparam interval_t INT_PASSENGER = 2'b10;
  localparam interval_t INT_ALARM_ON  = 2'b11;

  localparam int unsigned T_ARM_DEFAULT       = 6;
  localparam int unsigned T_DRIVER_DEFAULT    = 8;
  localparam int unsigned T_PASSENGER_DEFAULT = 15;
  localparam int unsigned T_ALARM_ON_DEFAULT  = 10;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StCount = 2'b01,
    StDone  = 2'b10
  } timer_state_e;

endpackage

// File: rtl/timer_controller_if.sv
// Request/status bundle between the alarm FSM (master) and the countdown
// timer (slave).
interface timer_controller_if #(
  parameter int unsigned VALUE_W = 4
);
  logic               start_timer;
  logic [1:0]         interval;
  logic               reprogram;
  logic [1:0]         time_param_sel;
  logic [VALUE_W-1:0] time_value;
  logic               expired;
  logic               one_hz_enable;
  logic               busy;
  logic [VALUE_W-1:0] remaining;

  modport master (
    output start_timer, interval, reprogram, time_param_sel, time_value,
    input  expired, one_hz_enable, busy, remaining
  );

  modport slave (
    input  start_timer, interval, reprogram, time_param_sel, time_value,
    output expired, one_hz_enable, busy, remaining
  );
endinterface

// File: rtl/one_hz_divider.sv
// Free-running clock divider producing a one-cycle tick every CLK_FREQ_HZ
// cycles; clear_i restarts the period so the next tick is a full period away.
module one_hz_divider #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o
);
  localparam int unsigned CntW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_FREQ_HZ - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear_i || (cnt_q == CntMax)) begin
      cnt_d = '0;
    end
  end

  assign tick_o = (cnt_q == CntMax);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/timer_controller.sv
// Countdown timer for the alarm FSM: holds four programmable durations, counts
// the selected one in 1 Hz ticks and pulses expired when it reaches zero.
module timer_controller #(
  parameter int unsigned CLK_FREQ_HZ         = 100_000_000,
  parameter int unsigned VALUE_W             = 4,
  parameter int unsigned T_ARM_DEFAULT       = antifurto_pkg::T_ARM_DEFAULT,
  parameter int unsigned T_DRIVER_DEFAULT    = antifurto_pkg::T_DRIVER_DEFAULT,
  parameter int unsigned T_PASSENGER_DEFAULT = antifurto_pkg::T_PASSENGER_DEFAULT,
  parameter int unsigned T_ALARM_ON_DEFAULT  = antifurto_pkg::T_ALARM_ON_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  timer_controller_if.slave        bus
);
  import antifurto_pkg::*;

  timer_state_e       state_d, state_q;
  logic [VALUE_W-1:0] remaining_d, remaining_q;
  logic [VALUE_W-1:0] params_d [4];
  logic [VALUE_W-1:0] params_q [4];
  logic               tick;

  one_hz_divider #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_divider (
    .clock   (clock),
    .reset   (reset),
    .clear_i (bus.start_timer),
    .tick_o  (tick)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    params_d    = params_q;

    if (bus.reprogram && (bus.time_value != '0)) begin
      params_d[bus.time_param_sel] = bus.time_value;
    end

    // Start wins over a coincident tick and reads the pre-write parameter.
    if (bus.start_timer) begin
      remaining_d = params_q[bus.interval];
      state_d     = StCount;
    end else begin
      unique case (state_q)
        StCount: begin
          if (tick) begin
            if (remaining_q <= VALUE_W'(1)) begin
              remaining_d = '0;
              state_d     = StDone;
            end else begin
              remaining_d = remaining_q - VALUE_W'(1);
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.expired       = (state_q == StDone);
  assign bus.busy          = (state_q == StCount);
  assign bus.remaining     = remaining_q;
  assign bus.one_hz_enable = tick;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q                  <= StIdle;
      remaining_q              <= '0;
      params_q[INT_ARM]        <= VALUE_W'(T_ARM_DEFAULT);
      params_q[INT_DRIVER]     <= VALUE_W'(T_DRIVER_DEFAULT);
      params_q[INT_PASSENGER]  <= VALUE_W'(T_PASSENGER_DEFAULT);
      params_q[INT_ALARM_ON]   <= VALUE_W'(T_ALARM_ON_DEFAULT);
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      params_q    <= params_d;
    end
  end
endmodule

// File: tb/tb_timer_controller.sv
// Self-checking bench for timer_controller: explicit vector table, directed
// multi-cycle sequences and random stimulus against a time-based model.
module tb_timer_controller;
  localparam int unsigned Clk = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  timer_controller_if #(.VALUE_W(4)) bus ();

  timer_controller #(
    .CLK_FREQ_HZ (Clk),
    .VALUE_W     (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: outputs derived from the number of edges since the last load/clear.
  int edge_n     = 0;
  int load_edge  = 0;
  int clear_edge = 0;
  int load_n     = 0;
  bit have_load  = 0;
  int m_param [4] = '{6, 8, 15, 10};
  int m_rem, m_busy, m_exp, m_hz;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", name, edge_n, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit st, input logic [1:0] iv,
                      input bit rp, input logic [1:0] sel, input logic [3:0] val);
    int d, t;
    reset              = rst;
    bus.start_timer    = st;
    bus.interval       = iv;
    bus.reprogram      = rp;
    bus.time_param_sel = sel;
    bus.time_value     = val;
    @(posedge clock);
    edge_n++;
    if (rst) begin
      m_param    = '{6, 8, 15, 10};
      have_load  = 0;
      clear_edge = edge_n;
    end else begin
      if (st) begin
        load_n     = m_param[iv];
        load_edge  = edge_n;
        clear_edge = edge_n;
        have_load  = 1;
      end
      if (rp && val != 0) m_param[sel] = int'(val);
    end
    d = edge_n - load_edge;
    t = d / Clk;
    if (!have_load) begin
      m_rem = 0; m_busy = 0; m_exp = 0;
    end else begin
      m_rem  = (t >= load_n) ? 0 : load_n - t;
      m_busy = (t < load_n) ? 1 : 0;
      m_exp  = (d == load_n * Clk) ? 1 : 0;
    end
    m_hz = (((edge_n - clear_edge) % Clk) == Clk - 1) ? 1 : 0;
    #1;
    chk("model_remaining", int'(bus.remaining), m_rem);
    chk("model_busy", int'(bus.busy), m_busy);
    chk("model_expired", int'(bus.expired), m_exp);
    chk("model_one_hz", int'(bus.one_hz_enable), m_hz);
  endtask

  task automatic idle();
    step(0, 0, 2'd0, 0, 2'd0, 4'd0);
  endtask

  task automatic start(input logic [1:0] iv);
    step(0, 1, iv, 0, 2'd0, 4'd0);
  endtask

  // Steps idle until expired is seen; k is the number of idle steps taken.
  task automatic wait_expired(input int max_steps, output int k);
    k = 0;
    do begin
      idle();
      k++;
    end while (!bus.expired && k < max_steps);
  endtask

  typedef struct {
    bit         rst;
    bit         st;
    logic [1:0] iv;
    bit         rp;
    logic [1:0] sel;
    logic [3:0] val;
    int         rem;
    bit         busy;
    bit         exp;
    bit         hz;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int k, hz_cnt;

    tbl[0]  = '{1, 0, 2'd0, 0, 2'd0, 4'd0, 0,  0, 0, 0};
    tbl[1]  = '{0, 1, 2'd1, 0, 2'd0, 4'd0, 8,  1, 0, 0};
    tbl[2]  = '{0, 0, 2'd0, 0, 2'd0, 4'd0, 8,  1, 0, 0};
    tbl[3]  = '{0, 0, 2'd0, 0, 2'd0, 4'd0, 8,  1, 0, 0};
    tbl[4]  = '{0, 0, 2'd0, 0, 2'd0, 4'd0, 8,  1, 0, 1};
    tbl[5]  = '{0, 0, 2'd0, 0, 2'd0, 4'd0, 7,  1, 0, 0};
    tbl[6]  = '{0, 0, 2'd0, 1, 2'd2, 4'd3, 7,  1, 0, 0};
    tbl[7]  = '{0, 1, 2'd2, 0, 2'd0, 4'd0, 3,  1, 0, 0};
    tbl[8]  = '{0, 0, 2'd0, 1, 2'd2, 4'd0, 3,  1, 0, 0};
    tbl[9]  = '{0, 1, 2'd3, 1, 2'd3, 4'd5, 10, 1, 0, 0};
    tbl[10] = '{0, 1, 2'd3, 0, 2'd0, 4'd0, 5,  1, 0, 0};
    tbl[11] = '{1, 0, 2'd0, 0, 2'd0, 4'd0, 0,  0, 0, 0};
    tbl[12] = '{0, 1, 2'd2, 0, 2'd0, 4'd0, 15, 1, 0, 0};
    tbl[13] = '{0, 1, 2'd0, 0, 2'd0, 4'd0, 6,  1, 0, 0};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst, tbl[i].st, tbl[i].iv, tbl[i].rp, tbl[i].sel, tbl[i].val);
      chk($sformatf("vec%0d_remaining", i), int'(bus.remaining), tbl[i].rem);
      chk($sformatf("vec%0d_busy", i), int'(bus.busy), int'(tbl[i].busy));
      chk($sformatf("vec%0d_expired", i), int'(bus.expired), int'(tbl[i].exp));
      chk($sformatf("vec%0d_one_hz", i), int'(bus.one_hz_enable), int'(tbl[i].hz));
    end

    // Full driver-door countdown: expired in cycle 8*4+1 counting the load cycle.
    step(1, 0, 2'd0, 0, 2'd0, 4'd0);
    start(2'd1);
    wait_expired(60, k);
    chk("driver_delay", k + 1, 8 * 4 + 1);
    idle();
    chk("driver_busy_after", int'(bus.busy), 0);
    chk("driver_expired_once", int'(bus.expired), 0);

    // Reprogrammed passenger delay, then a zero write that must be ignored.
    step(0, 0, 2'd0, 1, 2'd2, 4'd3);
    start(2'd2);
    chk("pass3_remaining", int'(bus.remaining), 3);
    wait_expired(60, k);
    chk("pass3_delay", k + 1, 13);
    step(0, 0, 2'd0, 1, 2'd2, 4'd0);
    start(2'd2);
    chk("pass_zero_ignored", int'(bus.remaining), 3);

    // Restart mid-count: reload to 6 after two ticks of the 10 s count.
    start(2'd3);
    for (int i = 0; i < 8; i++) idle();
    chk("restart_before", int'(bus.remaining), 8);
    start(2'd0);
    chk("restart_reload", int'(bus.remaining), 6);
    wait_expired(100, k);
    chk("restart_delay", k, 6 * 4);

    // Reprogram while counting does not disturb the running count.
    start(2'd3);
    for (int i = 0; i < 4; i++) idle();
    step(0, 0, 2'd0, 1, 2'd3, 4'd5);
    wait_expired(100, k);
    chk("reprog_running_delay", k + 5, 10 * 4);
    start(2'd3);
    chk("reprog_next_load", int'(bus.remaining), 5);

    // Reset in COUNT with remaining=4.
    start(2'd1);
    for (int i = 0; i < 16; i++) idle();
    chk("rst_mid_pre", int'(bus.remaining), 4);
    step(1, 0, 2'd0, 0, 2'd0, 4'd0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_remaining", int'(bus.remaining), 0);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (bus.expired) k++;
    end
    chk("rst_mid_no_expired", k, 0);
    start(2'd1);
    chk("rst_mid_default", int'(bus.remaining), 8);

    // Free-running divider: one strobe per 4 cycles.
    hz_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      idle();
      if (bus.one_hz_enable) hz_cnt++;
    end
    chk("one_hz_rate", hz_cnt, 4);

    // Start coinciding with a tick loads without decrementing.
    start(2'd0);
    for (int i = 0; i < 3; i++) idle();
    chk("tick_aligned", int'(bus.one_hz_enable), 1);
    start(2'd0);
    chk("start_over_tick", int'(bus.remaining), 6);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(499) == 0, $urandom_range(63) == 0, 2'($urandom_range(3)),
           $urandom_range(7) == 0, 2'($urandom_range(3)), 4'($urandom_range(15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
